// File: rtl/bus_demux2_pkg.sv
// Shared core-bus definitions: widths, target-B window, router FSM states
// and the address decode helper also used for PMA checks in the LSU.
package core_bus_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   localparam logic [ADDR_W-1:0] B_BASE = 32'h1000_0000;
   localparam logic [ADDR_W-1:0] B_MASK = 32'hF000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   // Request payload as latched on acceptance
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } req_t;

   function automatic logic is_target_b(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] base,
                                        input logic [ADDR_W-1:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/bus_demux2_if.sv
// Core-side and both target-side bus signals of the 1:2 data-bus router.
interface bus_demux2_if
   import core_bus_pkg::*;
#(
   parameter int unsigned DW = DATA_W,
   parameter int unsigned AW = ADDR_W
);
   localparam int unsigned BW = DW / 8;

   // core side
   logic          req_valid_i;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i;
   logic          req_we_i;
   logic [BW-1:0] req_be_i;
   logic [DW-1:0] req_wdata_i;
   logic          rsp_valid_o;
   logic [DW-1:0] rsp_rdata_o;

   // target A
   logic          a_req_valid_o;
   logic          a_req_ready_i;
   logic [AW-1:0] a_addr_o;
   logic          a_we_o;
   logic [BW-1:0] a_be_o;
   logic [DW-1:0] a_wdata_o;
   logic          a_rsp_valid_i;
   logic [DW-1:0] a_rsp_rdata_i;

   // target B
   logic          b_req_valid_o;
   logic          b_req_ready_i;
   logic [AW-1:0] b_addr_o;
   logic          b_we_o;
   logic [BW-1:0] b_be_o;
   logic [DW-1:0] b_wdata_o;
   logic          b_rsp_valid_i;
   logic [DW-1:0] b_rsp_rdata_i;

   // Router view
   modport slave (
      input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o,
      output a_req_valid_o, a_addr_o, a_we_o, a_be_o, a_wdata_o,
      input  a_req_ready_i, a_rsp_valid_i, a_rsp_rdata_i,
      output b_req_valid_o, b_addr_o, b_we_o, b_be_o, b_wdata_o,
      input  b_req_ready_i, b_rsp_valid_i, b_rsp_rdata_i
   );

   // Core + targets view
   modport master (
      output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o,
      input  a_req_valid_o, a_addr_o, a_we_o, a_be_o, a_wdata_o,
      output a_req_ready_i, a_rsp_valid_i, a_rsp_rdata_i,
      input  b_req_valid_o, b_addr_o, b_we_o, b_be_o, b_wdata_o,
      output b_req_ready_i, b_rsp_valid_i, b_rsp_rdata_i
   );

endinterface

// File: rtl/bus_demux2.sv
// One-outstanding, registered 1:2 data-bus router: steers core requests to
// data memory (A) or MMIO (B) by address decode and returns the response.
module bus_demux2
   import core_bus_pkg::*;
#(
   parameter logic [ADDR_W-1:0] B_BASE_P = core_bus_pkg::B_BASE,
   parameter logic [ADDR_W-1:0] B_MASK_P = core_bus_pkg::B_MASK
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   bus_demux2_if.slave  bus
);

   state_e            state_q;
   req_t              req_q;
   logic              sel_b_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   logic tgt_ready_c;
   logic tgt_rsp_c;

   assign tgt_ready_c = sel_b_q ? bus.b_req_ready_i : bus.a_req_ready_i;
   assign tgt_rsp_c   = sel_b_q ? bus.b_rsp_valid_i : bus.a_rsp_valid_i;

   // Sequencer: accept -> issue to selected target -> wait for its response
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         req_q       <= '0;
         sel_b_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid_i) begin
                  req_q.addr  <= bus.req_addr_i;
                  req_q.we    <= bus.req_we_i;
                  req_q.be    <= bus.req_be_i;
                  req_q.wdata <= bus.req_wdata_i;
                  sel_b_q     <= is_target_b(bus.req_addr_i, B_BASE_P, B_MASK_P);
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (tgt_ready_c) state_q <= WAIT;
            end
            WAIT: begin
               // Responses from the unselected port never reach tgt_rsp_c
               if (tgt_rsp_c) begin
                  rsp_rdata_q <= sel_b_q ? bus.b_rsp_rdata_i : bus.a_rsp_rdata_i;
                  rsp_valid_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready_o   = (state_q == IDLE);
   assign bus.rsp_valid_o   = rsp_valid_q;
   assign bus.rsp_rdata_o   = rsp_rdata_q;

   // Payload is broadcast to both ports; only valid is steered
   assign bus.a_req_valid_o = (state_q == ISSUE) && !sel_b_q;
   assign bus.b_req_valid_o = (state_q == ISSUE) &&  sel_b_q;

   assign bus.a_addr_o      = req_q.addr;
   assign bus.a_we_o        = req_q.we;
   assign bus.a_be_o        = req_q.be;
   assign bus.a_wdata_o     = req_q.wdata;

   assign bus.b_addr_o      = req_q.addr;
   assign bus.b_we_o        = req_q.we;
   assign bus.b_be_o        = req_q.be;
   assign bus.b_wdata_o     = req_q.wdata;

endmodule

// File: tb/tb_bus_demux2.sv
// Scoreboard bench for bus_demux2: stimulus pushes expected target requests
// and core responses; a negedge monitor pops and compares them.
module tb_bus_demux2;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   always #5 clk_i = ~clk_i;

   bus_demux2_if bus ();

   bus_demux2 u_dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus.slave)
   );

   typedef struct packed {
      logic        b;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_req_t;

   exp_req_t    q_req[$];
   logic [31:0] q_rsp[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: target-side requests and core-side responses
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (bus.a_req_valid_o || bus.b_req_valid_o) begin
            chk("req_onehot", 64'(bus.a_req_valid_o & bus.b_req_valid_o), 64'd0);
            if (q_req.size() == 0) begin
               chk("req_unexpected", 64'd1, 64'd0);
            end else begin
               exp_req_t e;
               e = q_req[0];
               chk("req_port_sel", 64'(bus.b_req_valid_o), 64'(e.b));
               if ((bus.a_req_valid_o && bus.a_req_ready_i) ||
                   (bus.b_req_valid_o && bus.b_req_ready_i)) begin
                  void'(q_req.pop_front());
                  chk("a_addr",  64'(bus.a_addr_o),  64'(e.addr));
                  chk("b_addr",  64'(bus.b_addr_o),  64'(e.addr));
                  chk("we",      64'(e.b ? bus.b_we_o : bus.a_we_o),       64'(e.we));
                  chk("be",      64'(e.b ? bus.b_be_o : bus.a_be_o),       64'(e.be));
                  chk("wdata",   64'(e.b ? bus.b_wdata_o : bus.a_wdata_o), 64'(e.wdata));
               end
            end
         end
         if (bus.rsp_valid_o) begin
            if (q_rsp.size() == 0) begin
               chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(q_rsp.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drive one transaction; stall = cycles target withholds ready,
   // rdly = WAIT cycles until response (1 = first WAIT cycle)
   task automatic txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wdata, input int stall, input int rdly,
                      input logic [31:0] rdata, input bit spur, input bit b2b);
      exp_req_t e;
      int       n;
      e.b     = ((addr & 32'hF000_0000) == 32'h1000_0000);
      e.addr  = addr;
      e.we    = we;
      e.be    = be;
      e.wdata = wdata;
      q_req.push_back(e);
      q_rsp.push_back(rdata);

      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = addr;
      bus.req_we_i    = we;
      bus.req_be_i    = be;
      bus.req_wdata_i = wdata;
      if (b2b) begin
         chk("b2b_rsp_pulse", 64'(bus.rsp_valid_o), 64'd1);
         chk("b2b_ready",     64'(bus.req_ready_o), 64'd1);
      end
      n = 0;
      while (!bus.req_ready_o && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) chk("ready_timeout", 64'd1, 64'd0);
      tick();
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = 32'hFFFF_FFFF;
      bus.req_we_i    = ~we;
      bus.req_be_i    = ~be;
      bus.req_wdata_i = ~wdata;

      for (int i = 0; i < stall; i++) begin
         chk("stall_valid",   64'(e.b ? bus.b_req_valid_o : bus.a_req_valid_o), 64'd1);
         chk("stall_addr",    64'(e.b ? bus.b_addr_o : bus.a_addr_o),           64'(addr));
         chk("stall_wdata",   64'(e.b ? bus.b_wdata_o : bus.a_wdata_o),         64'(wdata));
         chk("stall_ready_o", 64'(bus.req_ready_o), 64'd0);
         tick();
      end
      chk("issue_valid",   64'(e.b ? bus.b_req_valid_o : bus.a_req_valid_o), 64'd1);
      chk("issue_ready_o", 64'(bus.req_ready_o), 64'd0);
      if (e.b) bus.b_req_ready_i = 1'b1; else bus.a_req_ready_i = 1'b1;
      tick();
      bus.a_req_ready_i = 1'b0;
      bus.b_req_ready_i = 1'b0;

      chk("wait_a_valid", 64'(bus.a_req_valid_o), 64'd0);
      chk("wait_b_valid", 64'(bus.b_req_valid_o), 64'd0);
      chk("wait_ready_o", 64'(bus.req_ready_o),   64'd0);
      for (int i = 0; i < rdly - 1; i++) begin
         if (spur && i == 0) begin
            if (e.b) begin bus.a_rsp_valid_i = 1'b1; bus.a_rsp_rdata_i = 32'h1234; end
            else     begin bus.b_rsp_valid_i = 1'b1; bus.b_rsp_rdata_i = 32'h1234; end
         end
         tick();
         bus.a_rsp_valid_i = 1'b0;
         bus.b_rsp_valid_i = 1'b0;
         chk("wait_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
      end
      if (e.b) begin bus.b_rsp_valid_i = 1'b1; bus.b_rsp_rdata_i = rdata; end
      else     begin bus.a_rsp_valid_i = 1'b1; bus.a_rsp_rdata_i = rdata; end
      tick();
      bus.a_rsp_valid_i = 1'b0;
      bus.b_rsp_valid_i = 1'b0;
      bus.a_rsp_rdata_i = 32'h5555_5555;
      bus.b_rsp_rdata_i = 32'h6666_6666;
      chk("rsp_pulse",     64'(bus.rsp_valid_o), 64'd1);
      chk("rsp_ready_o",   64'(bus.req_ready_o), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid_i   = 1'b0;
      bus.req_addr_i    = '0;
      bus.req_we_i      = 1'b0;
      bus.req_be_i      = '0;
      bus.req_wdata_i   = '0;
      bus.a_req_ready_i = 1'b0;
      bus.b_req_ready_i = 1'b0;
      bus.a_rsp_valid_i = 1'b0;
      bus.b_rsp_valid_i = 1'b0;
      bus.a_rsp_rdata_i = '0;
      bus.b_rsp_rdata_i = '0;

      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      chk("rst_ready_o", 64'(bus.req_ready_o),   64'd1);
      chk("rst_a_valid", 64'(bus.a_req_valid_o), 64'd0);
      chk("rst_b_valid", 64'(bus.b_req_valid_o), 64'd0);
      chk("rst_rsp_vld", 64'(bus.rsp_valid_o),   64'd0);
      chk("rst_rdata",   64'(bus.rsp_rdata_o),   64'd0);
      chk("rst_a_addr",  64'(bus.a_addr_o),      64'd0);
      tick();

      // Load from data memory, immediate ready, response two cycles after accept
      txn(32'h0000_0040, 1'b0, 4'hF, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tick();
      chk("rdata_holds", 64'(bus.rsp_rdata_o), 64'h0000_0000_DEAD_BEEF);
      chk("pulse_once",  64'(bus.rsp_valid_o), 64'd0);

      // Store to MMIO
      txn(32'h1000_0004, 1'b1, 4'b0001, 32'h0000_00A5, 0, 2, 32'h0000_0000, 1'b0, 1'b0);
      tick();

      // Target A stalls 5 cycles
      txn(32'h0000_1000, 1'b0, 4'hF, 32'h0, 5, 1, 32'hCAFE_0001, 1'b0, 1'b0);
      tick();

      // Spurious B response while waiting on A
      txn(32'h2000_0008, 1'b0, 4'hF, 32'h0, 0, 3, 32'h0BAD_F00D, 1'b1, 1'b0);
      tick();

      // Back-to-back: second accepted in the response-pulse cycle
      txn(32'h1FFF_FFFC, 1'b0, 4'hF, 32'h0, 1, 2, 32'h1111_2222, 1'b0, 1'b0);
      txn(32'h0FFF_FFFC, 1'b1, 4'b1100, 32'hA5A5_5A5A, 0, 1, 32'h3333_4444, 1'b0, 1'b1);
      tick();

      // Reset while in WAIT, late A response ignored
      begin
         exp_req_t e;
         e.b = 1'b0; e.addr = 32'h0000_0080; e.we = 1'b0; e.be = 4'hF; e.wdata = 32'h0;
         q_req.push_back(e);
         bus.req_valid_i = 1'b1;
         bus.req_addr_i  = 32'h0000_0080;
         bus.req_we_i    = 1'b0;
         bus.req_be_i    = 4'hF;
         bus.req_wdata_i = 32'h0;
         tick();
         bus.req_valid_i   = 1'b0;
         bus.a_req_ready_i = 1'b1;
         tick();
         bus.a_req_ready_i = 1'b0;
         chk("pre_rst_wait", 64'(bus.req_ready_o), 64'd0);
         rst_ni = 1'b0;
         tick();
         rst_ni = 1'b1;
         chk("mid_rst_ready_o", 64'(bus.req_ready_o),   64'd1);
         chk("mid_rst_a_valid", 64'(bus.a_req_valid_o), 64'd0);
         chk("mid_rst_rdata",   64'(bus.rsp_rdata_o),   64'd0);
         chk("mid_rst_a_addr",  64'(bus.a_addr_o),      64'd0);
         bus.a_rsp_valid_i = 1'b1;
         bus.a_rsp_rdata_i = 32'h0000_0BAD;
         tick();
         bus.a_rsp_valid_i = 1'b0;
         chk("late_rsp_ignored", 64'(bus.rsp_valid_o), 64'd0);
         tick();
         chk("late_rsp_ignored2", 64'(bus.rsp_valid_o), 64'd0);
         chk("late_rsp_rdata",    64'(bus.rsp_rdata_o), 64'd0);
      end

      // Normal operation after reset
      txn(32'h1000_0010, 1'b0, 4'hF, 32'h0, 2, 1, 32'h7777_8888, 1'b0, 1'b0);
      tick();
      tick();

      chk("req_queue_empty", 64'(q_req.size()), 64'd0);
      chk("rsp_queue_empty", 64'(q_rsp.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bus_demux2.md
Name: bus_demux2

Overview:
- Single-initiator, dual-target data-bus router for the RISC-V core's load/store path.
- It is the fan-out counterpart of the core's 2:1 datapath select: one core request stream is steered to target A (data memory) or target B (MMIO) by address decode.
- The selected target's response is returned to the core.
- It is a registered, one-outstanding-transaction router with valid/ready request handshakes on both sides.

Parameters:
- DATA_W, 32, data width of wdata/rdata.
- ADDR_W, 32, address width.
- B_BASE, 32'h1000_0000, match value for target B.
- B_MASK, 32'hF000_0000, address bits compared for target B.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  router can accept a request.
- req_addr_i  in  ADDR_W  request address.
- req_we_i  in  1  1 = store, 0 = load.
- req_be_i  in  DATA_W/8  byte enables.
- req_wdata_i  in  DATA_W  store data.
- rsp_valid_o  out  1  one-cycle response pulse to core.
- rsp_rdata_o  out  DATA_W  response data; holds until the next response.
- a_req_valid_o / b_req_valid_o  out  1  target request valid.
- a_req_ready_i / b_req_ready_i  in  1  target accepts request.
- a_addr_o, a_we_o, a_be_o, a_wdata_o  out  (widths as core side)  target A request payload.
- b_addr_o, b_we_o, b_be_o, b_wdata_o  out  (widths as core side)  target B request payload.
- a_rsp_valid_i / b_rsp_valid_i  in  1  target response valid (stores acknowledge too).
- a_rsp_rdata_i / b_rsp_rdata_i  in  DATA_W  target response data.

Behaviour:
- Decode: sel_b = ((req_addr_i & B_MASK) == B_BASE); otherwise target A. There is no unmapped/error case.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - req_ready_o = 1, combinational from state only.
  - On req_valid_i, latch addr, we, be, wdata and sel_b into registers, then go to ISSUE.
- ISSUE:
  - Assert the selected x_req_valid_o = 1; the other port's valid stays 0.
  - The payload outputs of both ports carry the latched fields; only valid is gated.
  - On x_req_ready_i of the selected port, go to WAIT. Valid and payload stay stable until accepted.
- WAIT:
  - On the selected x_rsp_valid_i, register x_rsp_rdata_i into rsp_rdata_o, set rsp_valid_o = 1 for exactly the next cycle, and go to IDLE.
  - For stores, rsp_rdata_o takes whatever the target drives.
- Responses on the unselected port, or in IDLE/ISSUE, are ignored.
- A target response in the same cycle as its request acceptance is not a valid response. Targets respond no earlier than the cycle after acceptance.
- Latency (no target stalls):
  - accept edge T: IDLE to ISSUE
  - ready at T+1: to WAIT
  - target response at T+2 or later: rsp_valid_o high one cycle later
  - Minimum period is 3 cycles per transaction, plus the response pulse.
- Back-to-back: while rsp_valid_o is high the FSM is already in IDLE with req_ready_o = 1, so a new request is accepted in that same cycle.
- Reset (rst_ni low at a rising edge):
  - State returns to IDLE.
  - All valids go to 0; rsp_rdata_o and the latched fields go to 0.
  - An in-flight transaction is abandoned. A late target response after reset arrives in IDLE and is ignored.
- Stall with no target ready: the FSM stays in ISSUE indefinitely. There is no timeout.

Decomposition:
- Shared package (core_bus_pkg):
  - state enum {IDLE, ISSUE, WAIT}
  - DATA_W/ADDR_W defaults
  - B_BASE/B_MASK defaults
  - decode function is_target_b(addr, base, mask), reused by the core's load/store unit for PMA checks.
- Single module, no sub-module.

Test Plan:
- Load 0x0000_0040 with target A ready immediately and a_rsp_rdata_i = 0xDEAD_BEEF two cycles later:
  - a_req_valid_o high for one cycle with a_addr_o = 0x40
  - b_req_valid_o stays 0
  - rsp_valid_o pulses once with rsp_rdata_o = 0xDEAD_BEEF
- Store 0x1000_0004, wdata 0x0000_00A5, be 4'b0001:
  - b_req_valid_o asserted with b_we_o = 1 and b_wdata_o = 0xA5
  - rsp_valid_o pulses after b_rsp_valid_i
  - a_req_valid_o never asserts
- Target A holds a_req_ready_i = 0 for 5 cycles:
  - a_req_valid_o and payload are stable for 6 cycles
  - req_ready_o = 0 throughout
- Spurious b_rsp_valid_i = 1 with rdata 0x1234 while waiting on target A:
  - ignored; rsp_rdata_o later equals A's data
- Back-to-back requests:
  - second request is accepted in the cycle rsp_valid_o is high
  - second transaction completes correctly
- rst_ni low during WAIT, then A responds after reset:
  - outputs are zero and state is IDLE
  - no rsp_valid_o pulse
